// File: rtl/bludge_arbiter.sv
// rtl/bludge_arbiter.sv - round-robin bludger arbiter with hold timeout and cooldown
//
// Grants the shared bludger to one player at a time. A grant holds until the
// victim reports the penalty served (clean_bludge) or a hold timeout expires.
// A cooldown of COOLDOWN_TICKS game ticks follows before the next grant.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   game_active    arbitration enable; low forces IDLE and clears the grant
//   hit_req        per-player collision request (level)
//   clean_bludge   per-player penalty-served indication
//   bludged        registered one-hot (or zero) grant to player controllers
//   victim         registered index of the current/last victim
//   busy           registered, high whenever not IDLE
//   cooldown_left  registered remaining cooldown ticks
//   hit_count      (BLUDGE_STATS_EN only) per-player saturating grant counters, 8 bits each
//   drop_count     (BLUDGE_STATS_EN only) saturating count of requests ignored while busy
//
// Optional feature macro: BLUDGE_STATS_EN

module bludge_arbiter #(
    parameter int N_PLAYERS      = 4,
    parameter int TICK_DIV       = 50000000,
    parameter int COOLDOWN_TICKS = 3,
    parameter int MAX_HOLD_TICKS = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         game_active,
    input  logic [N_PLAYERS-1:0]         hit_req,
    input  logic [N_PLAYERS-1:0]         clean_bludge,
    output logic [N_PLAYERS-1:0]         bludged,
    output logic [$clog2(N_PLAYERS)-1:0] victim,
    output logic                         busy,
    output logic [4:0]                   cooldown_left
`ifdef BLUDGE_STATS_EN
    ,
    output logic [N_PLAYERS*8-1:0]       hit_count,
    output logic [7:0]                   drop_count
`endif
);

    localparam int VW = $clog2(N_PLAYERS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BLUDGED  = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t          state;
    logic [VW-1:0]   rr_ptr;
    logic [PW-1:0]   presc;
    logic [4:0]      hold_cnt;

    logic            tick;
    logic            hold_expire;
    logic            found;
    logic [VW-1:0]   grant_idx;
    logic [VW-1:0]   next_ptr;

    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign hold_expire = tick && (hold_cnt == 5'(MAX_HOLD_TICKS - 1));
    assign next_ptr    = (victim == VW'(N_PLAYERS - 1)) ? '0 : victim + VW'(1);

    // First requester at or above rr_ptr, wrapping past the top index.
    always_comb begin : grant_search
        int idx;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            idx = (int'(rr_ptr) + i) % N_PLAYERS;
            if (!found && hit_req[idx]) begin
                found     = 1'b1;
                grant_idx = VW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bludged       <= '0;
            victim        <= '0;
            rr_ptr        <= '0;
            busy          <= 1'b0;
            cooldown_left <= '0;
            presc         <= '0;
            hold_cnt      <= '0;
        end else if (!game_active) begin
            // Soft clear: rr_ptr and victim survive so fairness resumes where it left off.
            state         <= IDLE;
            bludged       <= '0;
            busy          <= 1'b0;
            cooldown_left <= '0;
            presc         <= '0;
            hold_cnt      <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            case (state)
                IDLE: begin
                    if (found) begin
                        state              <= BLUDGED;
                        bludged            <= '0;
                        bludged[grant_idx] <= 1'b1;
                        victim             <= grant_idx;
                        busy               <= 1'b1;
                        presc              <= '0;
                        hold_cnt           <= '0;
                    end
                end
                BLUDGED: begin
                    // Clean and timeout lead to the same release, so one branch serves both.
                    if (clean_bludge[victim] || hold_expire) begin
                        state         <= COOLDOWN;
                        bludged       <= '0;
                        rr_ptr        <= next_ptr;
                        cooldown_left <= 5'(COOLDOWN_TICKS);
                        presc         <= '0;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 5'd1;
                    end
                end
                COOLDOWN: begin
                    if (cooldown_left == 5'd0) begin
                        // Zero-length cooldown: leave on the cycle after release.
                        state <= IDLE;
                        busy  <= 1'b0;
                        presc <= '0;
                    end else if (tick) begin
                        cooldown_left <= cooldown_left - 5'd1;
                        if (cooldown_left == 5'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            presc <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bludged <= '0;
                    busy    <= 1'b0;
                    presc   <= '0;
                end
            endcase
        end
    end

`ifdef BLUDGE_STATS_EN
    logic [N_PLAYERS-1:0] hit_req_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            drop_count <= '0;
            hit_req_q  <= '0;
        end else begin
            hit_req_q <= hit_req;
            if (game_active && state == IDLE && found &&
                hit_count[int'(grant_idx)*8 +: 8] != 8'hFF) begin
                hit_count[int'(grant_idx)*8 +: 8] <= hit_count[int'(grant_idx)*8 +: 8] + 8'd1;
            end
            // A new collision while the bludger is taken is dropped, not queued.
            if ((state == BLUDGED || state == COOLDOWN) &&
                (|(hit_req & ~hit_req_q)) && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bludge_arbiter.sv
// tb/tb_bludge_arbiter.sv - directed self-checking bench for bludge_arbiter

module tb_bludge_arbiter;

    logic       clk;
    logic       rst_n;
    logic       game_active;
    logic [3:0] hit_req;
    logic [3:0] clean_bludge;
    logic [3:0] bludged;
    logic [1:0] victim;
    logic       busy;
    logic [4:0] cooldown_left;
`ifdef BLUDGE_STATS_EN
    logic [31:0] hit_count;
    logic [7:0]  drop_count;
`endif

    int checks = 0;
    int errors = 0;

    bludge_arbiter #(
        .N_PLAYERS(4),
        .TICK_DIV(4),
        .COOLDOWN_TICKS(2),
        .MAX_HOLD_TICKS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .game_active(game_active),
        .hit_req(hit_req),
        .clean_bludge(clean_bludge),
        .bludged(bludged),
        .victim(victim),
        .busy(busy),
        .cooldown_left(cooldown_left)
`ifdef BLUDGE_STATS_EN
        ,
        .hit_count(hit_count),
        .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; game_active = 1'b1; hit_req = 4'b1111; clean_bludge = 4'b0000;
        step(); step();
        checks++; if (bludged !== 4'b0000) begin errors++; $display("FAIL reset_bludged got %b want 0000", bludged); end
        checks++; if (victim !== 2'd0) begin errors++; $display("FAIL reset_victim got %0d want 0", victim); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cooldown_left !== 5'd0) begin errors++; $display("FAIL reset_cooldown got %0d want 0", cooldown_left); end
        rst_n = 1'b1; hit_req = 4'b0000;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy got %b want 0", busy); end
    endtask

    task automatic test_grant();
        hit_req = 4'b0100;
        step();
        checks++; if (bludged !== 4'b0100) begin errors++; $display("FAIL grant_bludged got %b want 0100", bludged); end
        checks++; if (victim !== 2'd2) begin errors++; $display("FAIL grant_victim got %0d want 2", victim); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grant_busy got %b want 1", busy); end
        hit_req = 4'b0000;
    endtask

    task automatic test_cooldown();
        clean_bludge = 4'b0001;
        step();
        checks++; if (bludged !== 4'b0100) begin errors++; $display("FAIL nonvictim_clean got %b want 0100", bludged); end
        clean_bludge = 4'b0100;
        step();
        checks++; if (bludged !== 4'b0000) begin errors++; $display("FAIL release_bludged got %b want 0000", bludged); end
        checks++; if (cooldown_left !== 5'd2) begin errors++; $display("FAIL release_cooldown got %0d want 2", cooldown_left); end
        clean_bludge = 4'b0000; hit_req = 4'b0001;
        repeat (3) step();
        checks++; if (cooldown_left !== 5'd2) begin errors++; $display("FAIL cooldown_r3 got %0d want 2", cooldown_left); end
        step();
        checks++; if (cooldown_left !== 5'd1) begin errors++; $display("FAIL cooldown_r4 got %0d want 1", cooldown_left); end
        checks++; if (bludged !== 4'b0000) begin errors++; $display("FAIL cooldown_no_grant got %b want 0000", bludged); end
        repeat (3) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cooldown_r7_busy got %b want 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cooldown_r8_busy got %b want 0", busy); end
        checks++; if (cooldown_left !== 5'd0) begin errors++; $display("FAIL cooldown_r8_left got %0d want 0", cooldown_left); end
        checks++; if (bludged !== 4'b0000) begin errors++; $display("FAIL cooldown_r8_bludged got %b want 0000", bludged); end
        hit_req = 4'b0000;
    endtask

    task automatic test_timeout();
        hit_req = 4'b0010;
        step();
        checks++; if (victim !== 2'd1) begin errors++; $display("FAIL timeout_grant_victim got %0d want 1", victim); end
        hit_req = 4'b0000;
        repeat (11) step();
        checks++; if (bludged !== 4'b0010) begin errors++; $display("FAIL timeout_hold11 got %b want 0010", bludged); end
        step();
        checks++; if (bludged !== 4'b0000) begin errors++; $display("FAIL timeout_release got %b want 0000", bludged); end
        checks++; if (cooldown_left !== 5'd2) begin errors++; $display("FAIL timeout_cooldown got %0d want 2", cooldown_left); end
        repeat (8) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        hit_req = 4'b1011;
        step();
        checks++; if (victim !== 2'd3) begin errors++; $display("FAIL rr_from2_victim got %0d want 3", victim); end
        checks++; if (bludged !== 4'b1000) begin errors++; $display("FAIL rr_from2_bludged got %b want 1000", bludged); end
        step();
        checks++; if (victim !== 2'd3) begin errors++; $display("FAIL rr_held_victim got %0d want 3", victim); end
        clean_bludge = 4'b1000;
        step();
        clean_bludge = 4'b0000;
        repeat (8) step();
        checks++; if (bludged !== 4'b0000) begin errors++; $display("FAIL rr_cooldown_end got %b want 0000", bludged); end
        step();
        checks++; if (victim !== 2'd0) begin errors++; $display("FAIL rr_wrap_victim got %0d want 0", victim); end
        checks++; if (bludged !== 4'b0001) begin errors++; $display("FAIL rr_wrap_bludged got %b want 0001", bludged); end
    endtask

    task automatic test_game_inactive();
        game_active = 1'b0;
        step();
        checks++; if (bludged !== 4'b0000) begin errors++; $display("FAIL inactive_bludged got %b want 0000", bludged); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inactive_busy got %b want 0", busy); end
        step();
        checks++; if (bludged !== 4'b0000) begin errors++; $display("FAIL inactive_no_grant got %b want 0000", bludged); end
        game_active = 1'b1; hit_req = 4'b0100;
        step();
        checks++; if (victim !== 2'd2) begin errors++; $display("FAIL inactive_regrant got %0d want 2", victim); end
        game_active = 1'b0;
        step();
        checks++; if (victim !== 2'd2) begin errors++; $display("FAIL inactive_victim_kept got %0d want 2", victim); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inactive_busy2 got %b want 0", busy); end
        game_active = 1'b1; hit_req = 4'b0110;
        step();
        checks++; if (victim !== 2'd1) begin errors++; $display("FAIL rrptr_kept_victim got %0d want 1", victim); end
        hit_req = 4'b0000;
    endtask

    task automatic test_reset_mid_cooldown();
        clean_bludge = 4'b0010;
        step();
        clean_bludge = 4'b0000;
        step();
        checks++; if (cooldown_left !== 5'd2) begin errors++; $display("FAIL pre_reset_cooldown got %0d want 2", cooldown_left); end
        rst_n = 1'b0;
        step();
        checks++; if ({bludged, victim, busy, cooldown_left} !== 12'd0) begin errors++; $display("FAIL reset_mid_cooldown got %b/%0d/%b/%0d want all 0", bludged, victim, busy, cooldown_left); end
        rst_n = 1'b1; hit_req = 4'b1111;
        step();
        checks++; if (victim !== 2'd0) begin errors++; $display("FAIL reset_rrptr_victim got %0d want 0", victim); end
        hit_req = 4'b0000; game_active = 1'b0;
        step();
        game_active = 1'b1;
    endtask

`ifdef BLUDGE_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; hit_req = 4'b0010;
        for (int k = 0; k < 300; k++) begin
            game_active = 1'b1;
            step();
            game_active = 1'b0;
            step();
        end
        checks++; if (hit_count[15:8] !== 8'd255) begin errors++; $display("FAIL stats_hit1 got %0d want 255", hit_count[15:8]); end
        checks++; if (hit_count[7:0] !== 8'd0) begin errors++; $display("FAIL stats_hit0 got %0d want 0", hit_count[7:0]); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL stats_drop0 got %0d want 0", drop_count); end
        game_active = 1'b1;
        step();
        hit_req = 4'b0110;
        step();
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL stats_drop1 got %0d want 1", drop_count); end
        checks++; if (bludged !== 4'b0010) begin errors++; $display("FAIL stats_no_regrant got %b want 0010", bludged); end
        hit_req = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_grant();
        test_cooldown();
        test_timeout();
        test_round_robin();
        test_game_inactive();
        test_reset_mid_cooldown();
`ifdef BLUDGE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
